// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline forwarding/hazard controller:
// forward-select codes, the per-stage shadow slot and the controller FSM states.
package pipe_pkg;

    localparam int SLOT_DEST_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef struct packed {
        logic                   valid;
        logic                   regWrite;
        logic                   memRead;
        logic [SLOT_DEST_W-1:0] dest;
    } stageSlot_t;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        FREEZE
    } fsmState_t;

    // A producer satisfies a source read when it writes a non-zero register equal to it.
    function automatic logic destHit(
        input logic                   writes,
        input logic [SLOT_DEST_W-1:0] dest,
        input logic [SLOT_DEST_W-1:0] src
    );
        return writes && (dest != '0) && (dest == src);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Forward-select for one EX operand: compares a source register against the
// producers leaving EX and MEM; the younger (EX) producer takes precedence.
module fwd_match
    import pipe_pkg::*;
(
    input  logic                   iSrcValid,
    input  logic [SLOT_DEST_W-1:0] iSrc,
    input  logic                   iExWrites,
    input  logic [SLOT_DEST_W-1:0] iExDest,
    input  logic                   iMemWrites,
    input  logic [SLOT_DEST_W-1:0] iMemDest,
    output logic [1:0]             oCmd
);

    // NOTE: default assignment first so every path drives oCmd and no latch is inferred.
    always_comb begin
        oCmd = FWD_NONE;
        if (iSrcValid) begin
            if (destHit(iExWrites, iExDest, iSrc)) begin
                oCmd = FWD_MEM;
            end else if (destHit(iMemWrites, iMemDest, iSrc)) begin
                oCmd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// Optional statistics counters are built only when FORWARD_STATS_EN is defined.
module forward_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = SLOT_DEST_W,
    parameter int CNT_W      = 16
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iIdValid,
    input  logic [REG_ADDR_W-1:0] iIdRs,
    input  logic [REG_ADDR_W-1:0] iIdRt,
    input  logic [REG_ADDR_W-1:0] iIdDest,
    input  logic                  iIdRegWrite,
    input  logic                  iIdMemRead,
    input  logic                  iMemStall,
    output logic [1:0]            oForwardCmdA,
    output logic [1:0]            oForwardCmdB,
    output logic                  oStall,
    output logic                  oBubble,
    output logic [CNT_W-1:0]      oStallCount,
    output logic [CNT_W-1:0]      oFwdCount
);

    fsmState_t  state;
    fsmState_t  stateNext;
    stageSlot_t idSlot;
    stageSlot_t exSlot;
    stageSlot_t memSlot;
    stageSlot_t wbSlot;
    logic [1:0] cmdA;
    logic [1:0] cmdB;
    logic       loadUse;
    logic       advance;
    logic       insertBubble;

    assign idSlot = '{valid:    iIdValid,
                      regWrite: iIdRegWrite,
                      memRead:  iIdMemRead,
                      dest:     iIdDest};

    assign loadUse = iIdValid && exSlot.memRead &&
                     (destHit(exSlot.valid && exSlot.regWrite, exSlot.dest, iIdRs) ||
                      destHit(exSlot.valid && exSlot.regWrite, exSlot.dest, iIdRt));

    fwd_match uMatchA (
        .iSrcValid  (iIdValid),
        .iSrc       (iIdRs),
        .iExWrites  (exSlot.valid && exSlot.regWrite),
        .iExDest    (exSlot.dest),
        .iMemWrites (memSlot.valid && memSlot.regWrite),
        .iMemDest   (memSlot.dest),
        .oCmd       (cmdA)
    );

    fwd_match uMatchB (
        .iSrcValid  (iIdValid),
        .iSrc       (iIdRt),
        .iExWrites  (exSlot.valid && exSlot.regWrite),
        .iExDest    (exSlot.dest),
        .iMemWrites (memSlot.valid && memSlot.regWrite),
        .iMemDest   (memSlot.dest),
        .oCmd       (cmdB)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // The cycle that releases a freeze is evaluated like RUN, so the frozen
    // cycles exactly replace the advances they blocked.
    always_comb begin
        stateNext = state;
        unique case (state)
            RUN, FREEZE: begin
                if (iMemStall) begin
                    stateNext = FREEZE;
                end else if (loadUse) begin
                    stateNext = LOAD_STALL;
                end else begin
                    stateNext = RUN;
                end
            end
            LOAD_STALL: stateNext = iMemStall ? FREEZE : RUN;
            default:    stateNext = RUN;
        endcase
    end

    always_comb begin
        oStall       = 1'b0;
        oBubble      = 1'b0;
        advance      = 1'b0;
        insertBubble = 1'b0;
        unique case (state)
            RUN, FREEZE: begin
                if (iMemStall) begin
                    oStall = 1'b1;
                end else if (loadUse) begin
                    oStall       = 1'b1;
                    oBubble      = 1'b1;
                    insertBubble = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (iMemStall) begin
                    oStall = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments let the slot shift read every stage's old value.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            exSlot       <= '0;
            memSlot      <= '0;
            wbSlot       <= '0;
            oForwardCmdA <= FWD_NONE;
            oForwardCmdB <= FWD_NONE;
        end else if (advance) begin
            exSlot       <= idSlot;
            memSlot      <= exSlot;
            wbSlot       <= memSlot;
            oForwardCmdA <= cmdA;
            oForwardCmdB <= cmdB;
        end else if (insertBubble) begin
            exSlot       <= '0;
            memSlot      <= exSlot;
            wbSlot       <= memSlot;
            oForwardCmdA <= FWD_NONE;
            oForwardCmdB <= FWD_NONE;
        end
    end

    // A stall without a bubble is a freeze: no slot may move across it.
    assert property (@(posedge iClk) disable iff (iReset)
        (oStall && !oBubble) |=> $stable({exSlot, memSlot, wbSlot}));

`ifdef FORWARD_STATS_EN
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] fwdCount;
    logic [1:0]       fwdIssued;
    logic [CNT_W:0]   fwdSum;

    always_comb begin
        fwdIssued = {1'b0, cmdA != FWD_NONE} + {1'b0, cmdB != FWD_NONE};
        fwdSum    = {1'b0, fwdCount} + {{(CNT_W-1){1'b0}}, fwdIssued};
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stallCount <= '0;
            fwdCount   <= '0;
        end else begin
            if (oStall && (stallCount != '1)) begin
                stallCount <= stallCount + 1'b1;
            end
            if (advance) begin
                fwdCount <= fwdSum[CNT_W] ? '1 : fwdSum[CNT_W-1:0];
            end
        end
    end

    assign oStallCount = stallCount;
    assign oFwdCount   = fwdCount;
`else
    assign oStallCount = '0;
    assign oFwdCount   = '0;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus random
// instruction streams compared against an in-order pipeline occupancy model.
`timescale 1ns/1ps
module tb_forward_ctrl;

    localparam int RW     = 5;
    localparam int CW     = 8;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iIdValid;
    logic [RW-1:0] iIdRs;
    logic [RW-1:0] iIdRt;
    logic [RW-1:0] iIdDest;
    logic          iIdRegWrite;
    logic          iIdMemRead;
    logic          iMemStall;
    logic [1:0]    oForwardCmdA;
    logic [1:0]    oForwardCmdB;
    logic          oStall;
    logic          oBubble;
    logic [CW-1:0] oStallCount;
    logic [CW-1:0] oFwdCount;

    always #5 iClk = ~iClk;

    forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iIdValid     (iIdValid),
        .iIdRs        (iIdRs),
        .iIdRt        (iIdRt),
        .iIdDest      (iIdDest),
        .iIdRegWrite  (iIdRegWrite),
        .iIdMemRead   (iIdMemRead),
        .iMemStall    (iMemStall),
        .oForwardCmdA (oForwardCmdA),
        .oForwardCmdB (oForwardCmdB),
        .oStall       (oStall),
        .oBubble      (oBubble),
        .oStallCount  (oStallCount),
        .oFwdCount    (oFwdCount)
    );

    // Model: the instructions currently in EX and MEM (index 0 = youngest).
    typedef struct {
        bit valid;
        bit regWrite;
        bit memRead;
        int dest;
    } instr_t;

    instr_t     inFlight[2];
    logic [1:0] mCmdA;
    logic [1:0] mCmdB;
    int         mStallCnt;
    int         mFwdCnt;

    int nChecks = 0;
    int nPass   = 0;

    logic       obsStall;
    logic       obsBubble;
    logic [1:0] obsCmdA;
    logic [1:0] obsCmdB;
    logic [CW-1:0] obsStallCnt;
    logic [CW-1:0] obsFwdCnt;

    function automatic logic [1:0] modelCmd(input bit v, input int src);
        if (!v || src == 0) return 2'b00;
        for (int age = 0; age < 2; age++) begin
            if (inFlight[age].valid && inFlight[age].regWrite && inFlight[age].dest == src)
                return (age == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic modelClear();
        inFlight[0] = '{0, 0, 0, 0};
        inFlight[1] = '{0, 0, 0, 0};
        mCmdA = 2'b00;
        mCmdB = 2'b00;
        mStallCnt = 0;
        mFwdCnt = 0;
    endtask

    task automatic applyReset();
        @(negedge iClk);
        iReset = 1'b1;
        iIdValid = 1'b0; iIdRs = '0; iIdRt = '0; iIdDest = '0;
        iIdRegWrite = 1'b0; iIdMemRead = 1'b0; iMemStall = 1'b0;
        @(posedge iClk);
        modelClear();
    endtask

    // One pipeline cycle: drive ID, compare against the model, then clock the model.
    task automatic step(input bit v, input int rs, input int rt, input int dest,
                        input bit rw, input bit mr, input bit ms, input string tag);
        bit         hazard;
        bit         expStall;
        bit         expBubble;
        logic [1:0] nA;
        logic [1:0] nB;
        @(negedge iClk);
        iReset = 1'b0;
        iIdValid = v; iIdRs = RW'(rs); iIdRt = RW'(rt); iIdDest = RW'(dest);
        iIdRegWrite = rw; iIdMemRead = mr; iMemStall = ms;
        hazard = v && inFlight[0].valid && inFlight[0].regWrite && inFlight[0].memRead &&
                 inFlight[0].dest != 0 && (inFlight[0].dest == rs || inFlight[0].dest == rt);
        expStall  = ms || hazard;
        expBubble = !ms && hazard;
        #1;
        obsStall = oStall; obsBubble = oBubble;
        obsCmdA = oForwardCmdA; obsCmdB = oForwardCmdB;
        obsStallCnt = oStallCount; obsFwdCnt = oFwdCount;

        nChecks++;
        if (oStall !== expStall) $display("FAIL %s stall: got %b want %b", tag, oStall, expStall);
        else nPass++;
        nChecks++;
        if (oBubble !== expBubble) $display("FAIL %s bubble: got %b want %b", tag, oBubble, expBubble);
        else nPass++;
        nChecks++;
        if (oForwardCmdA !== mCmdA) $display("FAIL %s cmdA: got %b want %b", tag, oForwardCmdA, mCmdA);
        else nPass++;
        nChecks++;
        if (oForwardCmdB !== mCmdB) $display("FAIL %s cmdB: got %b want %b", tag, oForwardCmdB, mCmdB);
        else nPass++;
`ifdef FORWARD_STATS_EN
        nChecks++;
        if (oStallCount !== CW'(mStallCnt)) $display("FAIL %s stallCount: got %0d want %0d", tag, oStallCount, mStallCnt);
        else nPass++;
        nChecks++;
        if (oFwdCount !== CW'(mFwdCnt)) $display("FAIL %s fwdCount: got %0d want %0d", tag, oFwdCount, mFwdCnt);
        else nPass++;
`else
        nChecks++;
        if (oStallCount !== '0 || oFwdCount !== '0)
            $display("FAIL %s counters: got %0d/%0d want 0/0", tag, oStallCount, oFwdCount);
        else nPass++;
`endif

        @(posedge iClk);
        if (expStall && mStallCnt < CNTMAX) mStallCnt++;
        if (ms) begin
            // frozen: nothing moves
        end else if (hazard) begin
            inFlight[1] = inFlight[0];
            inFlight[0] = '{0, 0, 0, 0};
            mCmdA = 2'b00;
            mCmdB = 2'b00;
        end else begin
            nA = modelCmd(v, rs);
            nB = modelCmd(v, rt);
            mFwdCnt += int'(nA != 2'b00) + int'(nB != 2'b00);
            if (mFwdCnt > CNTMAX) mFwdCnt = CNTMAX;
            mCmdA = nA;
            mCmdB = nB;
            inFlight[1] = inFlight[0];
            inFlight[0] = '{v, rw, mr, dest};
        end
    endtask

    task automatic test_reset();
        applyReset();
        #1;
        nChecks++;
        if (oForwardCmdA !== 2'b00) $display("FAIL reset cmdA: got %b want 00", oForwardCmdA); else nPass++;
        nChecks++;
        if (oForwardCmdB !== 2'b00) $display("FAIL reset cmdB: got %b want 00", oForwardCmdB); else nPass++;
        nChecks++;
        if (oStall !== 1'b0) $display("FAIL reset stall: got %b want 0", oStall); else nPass++;
        nChecks++;
        if (oBubble !== 1'b0) $display("FAIL reset bubble: got %b want 0", oBubble); else nPass++;
        nChecks++;
        if (oStallCount !== '0 || oFwdCount !== '0)
            $display("FAIL reset counters: got %0d/%0d want 0/0", oStallCount, oFwdCount);
        else nPass++;
    endtask

    task automatic test_fwd_ex();
        applyReset();
        step(1, 1, 2, 3, 1, 0, 0, "ex_add_r3");
        step(1, 3, 5, 4, 1, 0, 0, "ex_add_r4");
        nChecks++;
        if (obsStall !== 1'b0) $display("FAIL ex_fwd no_stall: got %b want 0", obsStall); else nPass++;
        step(0, 0, 0, 0, 0, 0, 0, "ex_nop");
        nChecks++;
        if (obsCmdA !== 2'b01) $display("FAIL ex_fwd cmdA: got %b want 01", obsCmdA); else nPass++;
        nChecks++;
        if (obsCmdB !== 2'b00) $display("FAIL ex_fwd cmdB: got %b want 00", obsCmdB); else nPass++;
    endtask

    task automatic test_fwd_wb();
        applyReset();
        step(1, 1, 2, 3, 1, 0, 0, "wb_add_r3");
        step(0, 0, 0, 0, 0, 0, 0, "wb_nop");
        step(1, 1, 3, 6, 1, 0, 0, "wb_sub_r6");
        step(0, 0, 0, 0, 0, 0, 0, "wb_nop2");
        nChecks++;
        if (obsCmdB !== 2'b10) $display("FAIL wb_fwd cmdB: got %b want 10", obsCmdB); else nPass++;
        nChecks++;
        if (obsCmdA !== 2'b00) $display("FAIL wb_fwd cmdA: got %b want 00", obsCmdA); else nPass++;
    endtask

    task automatic test_load_use();
        applyReset();
        step(1, 1, 0, 2, 1, 1, 0, "lu_lw_r2");
        step(1, 2, 2, 7, 1, 0, 0, "lu_add_stall");
        nChecks++;
        if (obsStall !== 1'b1 || obsBubble !== 1'b1)
            $display("FAIL load_use stall_bubble: got %b%b want 11", obsStall, obsBubble);
        else nPass++;
        step(1, 2, 2, 7, 1, 0, 0, "lu_add_go");
        nChecks++;
        if (obsStall !== 1'b0 || obsBubble !== 1'b0)
            $display("FAIL load_use one_cycle: got %b%b want 00", obsStall, obsBubble);
        else nPass++;
        step(0, 0, 0, 0, 0, 0, 0, "lu_nop");
        nChecks++;
        if (obsCmdA !== 2'b10 || obsCmdB !== 2'b10)
            $display("FAIL load_use cmds: got %b/%b want 10/10", obsCmdA, obsCmdB);
        else nPass++;
    endtask

    task automatic test_zero_and_newest();
        applyReset();
        step(1, 1, 1, 0, 1, 0, 0, "z_add_r0");
        step(1, 0, 0, 8, 1, 0, 0, "z_read_r0");
        step(0, 0, 0, 0, 0, 0, 0, "z_nop");
        nChecks++;
        if (obsCmdA !== 2'b00 || obsCmdB !== 2'b00)
            $display("FAIL r0_never_fwd cmds: got %b/%b want 00/00", obsCmdA, obsCmdB);
        else nPass++;
        step(1, 1, 2, 3, 1, 0, 0, "n_add_r3a");
        step(1, 1, 2, 3, 1, 0, 0, "n_add_r3b");
        step(1, 3, 3, 9, 1, 0, 0, "n_read_r3");
        step(0, 0, 0, 0, 0, 0, 0, "n_nop");
        nChecks++;
        if (obsCmdA !== 2'b01 || obsCmdB !== 2'b01)
            $display("FAIL newest_wins cmds: got %b/%b want 01/01", obsCmdA, obsCmdB);
        else nPass++;
    endtask

    task automatic test_freeze_load_use();
        int frozen = 0;
        applyReset();
        step(1, 1, 0, 2, 1, 1, 0, "fz_lw_r2");
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 2, 7, 1, 0, 1, "fz_held");
            if (obsStall === 1'b1 && obsBubble === 1'b0) frozen++;
        end
        nChecks++;
        if (frozen != 3) $display("FAIL freeze stall_no_bubble: got %0d cycles want 3", frozen); else nPass++;
        step(1, 2, 2, 7, 1, 0, 0, "fz_release");
        nChecks++;
        if (obsStall !== 1'b1 || obsBubble !== 1'b1)
            $display("FAIL freeze then_bubble: got %b%b want 11", obsStall, obsBubble);
        else nPass++;
        step(1, 2, 2, 7, 1, 0, 0, "fz_add_go");
        step(0, 0, 0, 0, 0, 0, 0, "fz_nop");
        nChecks++;
        if (obsCmdA !== 2'b10 || obsCmdB !== 2'b10)
            $display("FAIL freeze cmds: got %b/%b want 10/10", obsCmdA, obsCmdB);
        else nPass++;
    endtask

    task automatic test_reset_mid_stall();
        applyReset();
        step(1, 1, 0, 2, 1, 1, 0, "rm_lw_r2");
        step(1, 2, 2, 7, 1, 0, 1, "rm_frozen");
        applyReset();
        step(1, 2, 2, 7, 1, 0, 0, "rm_after");
        nChecks++;
        if (obsStall !== 1'b0 || obsBubble !== 1'b0 || obsCmdA !== 2'b00 || obsCmdB !== 2'b00)
            $display("FAIL reset_mid_stall outputs: got %b%b %b %b want 00 00 00", obsStall, obsBubble, obsCmdA, obsCmdB);
        else nPass++;
        nChecks++;
        if (obsStallCnt !== '0 || obsFwdCnt !== '0)
            $display("FAIL reset_mid_stall counters: got %0d/%0d want 0/0", obsStallCnt, obsFwdCnt);
        else nPass++;
    endtask

    task automatic test_random();
        applyReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, "random");
            end
        end
    endtask

    task automatic test_stats_saturate();
`ifdef FORWARD_STATS_EN
        applyReset();
        for (int i = 0; i < CNTMAX + 5; i++) step(0, 0, 0, 0, 0, 0, 1, "sat_stall");
        nChecks++;
        if (obsStallCnt !== {CW{1'b1}}) $display("FAIL stall_saturate: got %0d want %0d", obsStallCnt, CNTMAX);
        else nPass++;
        applyReset();
        for (int i = 0; i < CNTMAX / 2 + 5; i++) step(1, 3, 3, 3, 1, 0, 0, "sat_fwd");
        nChecks++;
        if (obsFwdCnt !== {CW{1'b1}}) $display("FAIL fwd_saturate: got %0d want %0d", obsFwdCnt, CNTMAX);
        else nPass++;
`else
        applyReset();
        for (int i = 0; i < 20; i++) step(1, 3, 3, 3, 1, 0, i[0], "stats_off");
        nChecks++;
        if (obsStallCnt !== '0 || obsFwdCnt !== '0)
            $display("FAIL stats_off counters: got %0d/%0d want 0/0", obsStallCnt, obsFwdCnt);
        else nPass++;
`endif
    endtask

    initial begin
        iReset = 1'b1;
        iIdValid = 1'b0; iIdRs = '0; iIdRt = '0; iIdDest = '0;
        iIdRegWrite = 1'b0; iIdMemRead = 1'b0; iMemStall = 1'b0;
        modelClear();
        test_reset();
        test_fwd_ex();
        test_fwd_wb();
        test_load_use();
        test_zero_and_newest();
        test_freeze_load_use();
        test_reset_mid_stall();
        test_random();
        test_stats_saturate();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Forwarding and hazard controller for the five-stage integer pipeline.
- Tracks destination-register info for the instructions in EX, MEM and WB in internal shadow slots.
- Produces registered 2-bit forward commands for the two EX-stage operand forward muxes.
- Detects load-use hazards and inserts a one-cycle stall plus bubble; honours an external memory freeze.

Parameters:
- REG_ADDR_W, 5: register-address width. Register 0 is hard-wired zero and is never forwarded.
- CNT_W, 16: width of the statistics counters (only used with FORWARD_STATS_EN).

Ports:
- iClk  in  1  pipeline clock
- iReset  in  1  synchronous, active-high reset
- iIdValid  in  1  ID stage holds a valid instruction
- iIdRs  in  REG_ADDR_W  ID source register A
- iIdRt  in  REG_ADDR_W  ID source register B
- iIdDest  in  REG_ADDR_W  ID destination register
- iIdRegWrite  in  1  ID instruction writes the register file
- iIdMemRead  in  1  ID instruction is a load
- iMemStall  in  1  data-memory busy; freeze the whole pipeline
- oForwardCmdA  out  2  EX operand A select: 00 = register file, 01 = MEM result, 10 = WB result
- oForwardCmdB  out  2  EX operand B select, same encoding
- oStall  out  1  hold PC and the IF/ID register
- oBubble  out  1  load NOP into ID/EX this cycle
- oStallCount  out  CNT_W  stall cycles (FORWARD_STATS_EN only)
- oFwdCount  out  CNT_W  forwards issued (FORWARD_STATS_EN only)

Behaviour:
- Shadow slots EX, MEM, WB each hold {valid, regWrite, memRead, dest}.
- Reset clears all slots, sets the FSM to RUN, drives oForwardCmdA/B = 00, oStall = 0, oBubble = 0 and clears both counters.
- oStall and oBubble are combinational from the FSM state and the current slots.
- oForwardCmdA/B are registered and are valid during the cycle the instruction occupies EX.
- Hazard match is defined as: slot.valid & slot.regWrite & slot.dest != 0 & slot.dest == src.
- Forward command computed at the ID→EX advance for each source register:
  - match against the EX slot (it moves to MEM): 01;
  - else match against the MEM slot (it moves to WB): 10;
  - else 00.
  - Most recent producer wins. 11 is never emitted.
- Load-use hazard: the EX slot is a load (memRead) and matches iIdRs or iIdRt, with iIdValid = 1.
- FSM states:
  - RUN:
    - load-use hazard → LOAD_STALL. In that same cycle assert oStall = 1 and oBubble = 1; at the edge EX gets an invalid bubble, EX→MEM and MEM→WB advance, and the ID slot does not advance.
    - iMemStall → FREEZE.
    - otherwise advance ID→EX→MEM→WB and register the new forward commands.
  - LOAD_STALL (one cycle only):
    - the load now sits in MEM and the dependent instruction advances normally, getting 10 for the load operand;
    - → RUN.
  - FREEZE:
    - oStall = 1, oBubble = 0; all slots and forward commands hold;
    - leaves to RUN on the first cycle with iMemStall = 0, with no lost or duplicated advance.
- Simultaneous events:
  - iMemStall has priority over a load-use hazard. The hazard is re-evaluated after the freeze, because slots did not move.
  - iMemStall asserted while in LOAD_STALL: the FSM moves to FREEZE and the bubble already inserted is kept.
- Reset mid-operation: the next cycle is clean per the reset values, and all in-flight slots are discarded.
- iIdValid = 0: the ID slot advances as an invalid entry, and the commands computed for it are 00.

Optional Feature:
- Macro FORWARD_STATS_EN.
- Defined:
  - oStallCount increments on every cycle with oStall = 1.
  - oFwdCount increments by the number of non-zero commands registered on an advance (0, 1 or 2).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both counters are tied to 0 and no counter flops are built.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - the stage-slot struct {valid, regWrite, memRead, dest};
  - the FSM state enum {RUN, LOAD_STALL, FREEZE}.
- Sub-module fwd_match: combinational compare of one source register against the EX and MEM slots, returning a 2-bit command. Instantiated twice, for A and B.

Test Plan:
- add r3 then add r4,r3,r5 back-to-back → second add in EX with oForwardCmdA = 01, no stall.
- add r3; nop; sub r6,r1,r3 → sub in EX with oForwardCmdB = 10.
- lw r2; add r7,r2,r2 → exactly 1 cycle of oStall = 1 and oBubble = 1, then the add gets A = B = 10.
- add r0 as producer, consumer reads r0 → commands 00. add r3 in both EX and MEM slots → 01 (most recent wins).
- iMemStall held 3 cycles during a load-use hazard → oStall high 3 cycles with oBubble = 0, then 1 stall cycle with bubble, then commands 10.
- Reset asserted mid-stall → next cycle all outputs 0, FSM in RUN. With FORWARD_STATS_EN defined, drive counters to all-ones and confirm they saturate.
